macrocell_configuration_block_loader: RTL and testbench

//   Deserialises the device bitstream into the parallel macrocell configuration block.

---
 rtl/macrocell_configuration_block_loader_if.sv | 24 ++
 rtl/macrocell_configuration_block_loader.sv | 91 +++++++++
 tb/tb_macrocell_configuration_block_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/macrocell_configuration_block_loader_if.sv
// Serial bitstream in, parallel configuration block and status out.
interface macrocell_configuration_block_loader_if #(
  parameter int unsigned Size = 416
);
  logic            stream_start;
  logic            bit_data;
  logic            bit_valid;
  logic            bit_last;
  logic            bit_ready;
  logic [Size-1:0] macrocell_configuration_block;
  logic            block_valid;
  logic            busy;
  logic            truncated;

  modport master (
    output stream_start, bit_data, bit_valid, bit_last,
    input  bit_ready, macrocell_configuration_block, block_valid, busy, truncated
  );

  modport slave (
    input  stream_start, bit_data, bit_valid, bit_last,
    output bit_ready, macrocell_configuration_block, block_valid, busy, truncated
  );
endinterface

// File: rtl/macrocell_configuration_block_loader.sv
// Deserialises the device bitstream into the macrocell configuration block:
// skips a fixed header, captures the block LSB-first, then drains the trailer.
// A bitstream that ends before the block is full is flagged as truncated.
module macrocell_configuration_block_loader #(
  parameter int unsigned NumLabs          = 2,
  parameter int unsigned MacrocellsPerLab = 16,
  parameter int unsigned BitsPerMacrocell = 13,
  parameter int unsigned BlockOffset      = 0
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset_n,
  macrocell_configuration_block_loader_if.slave io_bus
);
  localparam int unsigned BitsPerLab = MacrocellsPerLab * BitsPerMacrocell;
  localparam int unsigned SizeBlock  = NumLabs * BitsPerLab;
  localparam int unsigned CntMax     = (SizeBlock > BlockOffset) ? SizeBlock : BlockOffset;
  localparam int unsigned CntW       = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StSkip, StCapture, StTrail} state_e;

  state_e              r_state;
  logic [SizeBlock-1:0] r_block;
  logic                r_block_valid;
  logic                r_truncated;
  logic [CntW-1:0]     r_skip_cnt;
  logic [CntW-1:0]     r_cap_cnt;

  logic w_busy;
  logic w_ready;
  logic w_xfer;

  assign w_busy  = (r_state != StIdle);
  // A start pulse owns its cycle; no bit is taken alongside it.
  assign w_ready = w_busy & ~io_bus.stream_start;
  assign w_xfer  = io_bus.bit_valid & w_ready;

  assign io_bus.bit_ready                     = w_ready;
  assign io_bus.busy                          = w_busy;
  assign io_bus.macrocell_configuration_block = r_block;
  assign io_bus.block_valid                   = r_block_valid;
  assign io_bus.truncated                     = r_truncated;

  // Load FSM: reset, then start pulse, then per-transfer state advance.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_block       <= '0;
      r_block_valid <= 1'b0;
      r_truncated   <= 1'b0;
      r_skip_cnt    <= '0;
      r_cap_cnt     <= '0;
    end else if (io_bus.stream_start) begin
      r_state       <= (BlockOffset == 0) ? StCapture : StSkip;
      r_block       <= '0;
      r_block_valid <= 1'b0;
      r_truncated   <= 1'b0;
      r_skip_cnt    <= '0;
      r_cap_cnt     <= '0;
    end else if (w_xfer) begin
      unique case (r_state)
        StSkip: begin
          r_skip_cnt <= r_skip_cnt + CntW'(1);
          if (io_bus.bit_last) begin
            r_state     <= StIdle;
            r_truncated <= 1'b1;
          end else if (r_skip_cnt == CntW'(BlockOffset - 1)) begin
            r_state <= StCapture;
          end
        end
        StCapture: begin
          r_block[r_cap_cnt] <= io_bus.bit_data;
          r_cap_cnt          <= r_cap_cnt + CntW'(1);
          if (r_cap_cnt == CntW'(SizeBlock - 1)) begin
            r_block_valid <= 1'b1;
            r_state       <= io_bus.bit_last ? StIdle : StTrail;
          end else if (io_bus.bit_last) begin
            // Partial contents stay visible; only the flags report the short stream.
            r_state     <= StIdle;
            r_truncated <= 1'b1;
          end
        end
        StTrail: begin
          if (io_bus.bit_last) r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_macrocell_configuration_block_loader.sv
// Bench for the configuration block loader: three instances (small config with
// header, small config without header, default config). Expected end-of-load
// results are queued by the stimulus and checked by monitors when busy falls.
module tb_macrocell_configuration_block_loader;
  typedef struct {
    logic [415:0] blk;
    logic         bv;
    logic         tr;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic d_start [3];
  logic d_data  [3];
  logic d_valid [3];
  logic d_last  [3];
  logic prev_busy [3];

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  macrocell_configuration_block_loader_if #(.Size(6))   if_a ();
  macrocell_configuration_block_loader_if #(.Size(6))   if_b ();
  macrocell_configuration_block_loader_if #(.Size(416)) if_c ();

  assign if_a.stream_start = d_start[0];
  assign if_a.bit_data     = d_data[0];
  assign if_a.bit_valid    = d_valid[0];
  assign if_a.bit_last     = d_last[0];
  assign if_b.stream_start = d_start[1];
  assign if_b.bit_data     = d_data[1];
  assign if_b.bit_valid    = d_valid[1];
  assign if_b.bit_last     = d_last[1];
  assign if_c.stream_start = d_start[2];
  assign if_c.bit_data     = d_data[2];
  assign if_c.bit_valid    = d_valid[2];
  assign if_c.bit_last     = d_last[2];

  macrocell_configuration_block_loader #(
    .NumLabs(1), .MacrocellsPerLab(2), .BitsPerMacrocell(3), .BlockOffset(2)
  ) u_dut_a (.i_clock(clk), .i_reset_n(reset_n), .io_bus(if_a));

  macrocell_configuration_block_loader #(
    .NumLabs(1), .MacrocellsPerLab(2), .BitsPerMacrocell(3), .BlockOffset(0)
  ) u_dut_b (.i_clock(clk), .i_reset_n(reset_n), .io_bus(if_b));

  macrocell_configuration_block_loader u_dut_c (
    .i_clock(clk), .i_reset_n(reset_n), .io_bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [415:0] act, input logic [415:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cmp_done(input string tag, input logic [415:0] blk, input logic bv,
                          input logic tr, input exp_t e);
    chk({tag, ".block"}, blk, e.blk);
    chk({tag, ".block_valid"}, {415'b0, bv}, {415'b0, e.bv});
    chk({tag, ".truncated"}, {415'b0, tr}, {415'b0, e.tr});
  endtask

  function automatic exp_t mk(input logic [415:0] blk, input logic bv, input logic tr);
    exp_t e;
    e.blk = blk;
    e.bv  = bv;
    e.tr  = tr;
    return e;
  endfunction

  // Monitors: a load has ended whenever busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (prev_busy[0] === 1'b1 && if_a.busy === 1'b0) begin
      if (q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL mon_a: unexpected end of load, got busy=0, required no event");
      end else begin
        e = q0.pop_front();
        cmp_done("mon_a", {410'b0, if_a.macrocell_configuration_block},
                 if_a.block_valid, if_a.truncated, e);
      end
    end
    prev_busy[0] = if_a.busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (prev_busy[1] === 1'b1 && if_b.busy === 1'b0) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL mon_b: unexpected end of load, got busy=0, required no event");
      end else begin
        e = q1.pop_front();
        cmp_done("mon_b", {410'b0, if_b.macrocell_configuration_block},
                 if_b.block_valid, if_b.truncated, e);
      end
    end
    prev_busy[1] = if_b.busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (prev_busy[2] === 1'b1 && if_c.busy === 1'b0) begin
      if (q2.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL mon_c: unexpected end of load, got busy=0, required no event");
      end else begin
        e = q2.pop_front();
        cmp_done("mon_c", if_c.macrocell_configuration_block,
                 if_c.block_valid, if_c.truncated, e);
      end
    end
    prev_busy[2] = if_c.busy;
  end

  function automatic logic ready_of(input int k);
    case (k)
      0:       return if_a.bit_ready;
      1:       return if_b.bit_ready;
      default: return if_c.bit_ready;
    endcase
  endfunction

  // Start pulse with a valid bit alongside it, which must not be accepted.
  task automatic start(input int k, input string name);
    @(negedge clk);
    d_start[k] = 1'b1;
    d_valid[k] = 1'b1;
    d_data[k]  = 1'b1;
    #1;
    chk(name, {415'b0, ready_of(k)}, 416'd0);
    @(posedge clk);
    #1;
    d_start[k] = 1'b0;
    d_valid[k] = 1'b0;
    d_data[k]  = 1'b0;
  endtask

  task automatic send(input int k, input logic d, input logic last, input bit gap);
    @(negedge clk);
    d_valid[k] = 1'b1;
    d_data[k]  = d;
    d_last[k]  = last;
    @(posedge clk);
    #1;
    d_valid[k] = 1'b0;
    d_last[k]  = 1'b0;
    if (gap) @(posedge clk);
  endtask

  initial begin
    logic [8:0] s;
    logic [5:0] s6;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d_start[k] = 1'b0; d_data[k] = 1'b0; d_valid[k] = 1'b0; d_last[k] = 1'b0;
      prev_busy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    chk("rst.block",  {410'b0, if_a.macrocell_configuration_block}, 416'd0);
    chk("rst.bv",     {415'b0, if_a.block_valid}, 416'd0);
    chk("rst.busy",   {415'b0, if_a.busy}, 416'd0);
    chk("rst.trunc",  {415'b0, if_a.truncated}, 416'd0);
    chk("rst.blockc", if_c.macrocell_configuration_block, 416'd0);

    // Header 1,1 then block 1,0,1,1,0,0 then one trailer bit with last.
    s = 9'b000110111;
    q0.push_back(mk(416'b001101, 1'b1, 1'b0));
    start(0, "t1.ready_in_start");
    for (int i = 0; i < 9; i++) begin
      send(0, s[i], i == 8, 1'b0);
      if (i == 6) chk("t1.bv_before", {415'b0, if_a.block_valid}, 416'd0);
      if (i == 7) chk("t1.bv_after",  {415'b0, if_a.block_valid}, 416'd1);
    end

    // Same stream with gaps between valid bits.
    q0.push_back(mk(416'b001101, 1'b1, 1'b0));
    start(0, "t2.ready_in_start");
    for (int i = 0; i < 9; i++) send(0, s[i], i == 8, 1'b1);

    // Bitstream ends on the 5th transfer: three block bits captured.
    q0.push_back(mk(416'b000101, 1'b0, 1'b1));
    start(0, "t3.ready_in_start");
    for (int i = 0; i < 5; i++) send(0, s[i], i == 4, 1'b0);
    @(negedge clk);
    chk("t3.busy", {415'b0, if_a.busy}, 416'd0);

    // Restart mid-capture, then a full all-ones stream.
    q0.push_back(mk(416'b111111, 1'b1, 1'b0));
    start(0, "t4.ready_first_start");
    for (int i = 0; i < 4; i++) send(0, 1'b0, 1'b0, 1'b0);
    start(0, "t4.ready_restart");
    for (int i = 0; i < 9; i++) send(0, 1'b1, i == 8, 1'b0);

    // No header: last on the final block bit goes straight to idle.
    s6 = 6'b011001;
    q1.push_back(mk(416'b011001, 1'b1, 1'b0));
    start(1, "t5.ready_in_start");
    for (int i = 0; i < 6; i++) send(1, s6[i], i == 5, 1'b0);
    chk("t5.busy_after_last", {415'b0, if_b.busy}, 416'd0);

    // Default config, 416 alternating bits starting with 1.
    q2.push_back(mk({104{4'h5}}, 1'b1, 1'b0));
    start(2, "t6.ready_in_start");
    for (int i = 0; i < 416; i++) send(2, (i % 2) == 0, i == 415, 1'b0);

    // Reset in the middle of a load.
    q2.push_back(mk(416'd0, 1'b0, 1'b0));
    start(2, "t7.ready_in_start");
    for (int i = 0; i < 10; i++) send(2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t7.block", if_c.macrocell_configuration_block, 416'd0);
    chk("t7.bv",    {415'b0, if_c.block_valid}, 416'd0);
    chk("t7.busy",  {415'b0, if_c.busy}, 416'd0);
    chk("t7.trunc", {415'b0, if_c.truncated}, 416'd0);
    @(negedge clk);
    reset_n = 1'b1;

    repeat (4) @(posedge clk);
    chk("end.q0_empty", 416'(q0.size()), 416'd0);
    chk("end.q1_empty", 416'(q1.size()), 416'd0);
    chk("end.q2_empty", 416'(q2.size()), 416'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
